// File: rtl/port_link_if.sv
// One side of a port_link: the core's write/read handshake toward its neighbour.
// master = core side, slave = link side.
interface port_link_if #(parameter int WIDTH = 11);
  logic             write;
  logic [WIDTH-1:0] out;
  logic             wready;
  logic             read;
  logic             rready;
  logic [WIDTH-1:0] in;

  modport master (output write, out, read, input wready, rready, in);
  modport slave  (input write, out, read, output wready, rready, in);
endinterface

// File: rtl/port_link.sv
// Bidirectional one-word rendezvous mailbox between two neighbouring cores.
// Channel 0 carries A->B, channel 1 carries B->A; both are the same 4-state FSM.
//
// state | meaning
// EMPTY | no word held; a write captures out and moves to FULL
// FULL  | word valid to reader (rready); writer blocked until read
// ACK   | one-cycle wready pulse back to the writer
// GUARD | absorbs the writer's still-high write after it saw wready
module port_link #(
  parameter int WIDTH = 11
) (
  input logic         clk,
  input logic         rst,
  port_link_if.slave  a,
  port_link_if.slave  b
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    ACK   = 2'b10,
    GUARD = 2'b11
  } state_t;

  logic [1:0]       chWrite;
  logic [1:0]       chRead;
  logic [1:0]       chWready;
  logic [1:0]       chRready;
  logic [WIDTH-1:0] chWData [2];
  logic [WIDTH-1:0] chRData [2];

  assign chWrite    = {b.write, a.write};
  assign chRead     = {a.read, b.read};
  assign chWData[0] = a.out;
  assign chWData[1] = b.out;

  assign a.wready = chWready[0];
  assign b.rready = chRready[0];
  assign b.in     = chRData[0];
  assign b.wready = chWready[1];
  assign a.rready = chRready[1];
  assign a.in     = chRData[1];

  for (genvar c = 0; c < 2; c++) begin : g_chan
    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] data;
    logic             rReady;
    logic             wReady;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= EMPTY;
        data  <= '0;
      end else begin
        state <= nextState;
        // Capture only from EMPTY so a held write never overwrites a pending word.
        if (state == EMPTY && chWrite[c]) begin
          data <= chWData[c];
        end
      end
    end

    always_comb begin
      nextState = state;
      rReady    = 1'b0;
      wReady    = 1'b0;
      case (state)
        EMPTY: begin
          if (chWrite[c]) nextState = FULL;
        end
        FULL: begin
          rReady = 1'b1;
          if (chRead[c]) nextState = ACK;
        end
        ACK: begin
          wReady    = 1'b1;
          nextState = GUARD;
        end
        GUARD: begin
          nextState = EMPTY;
        end
        default: begin
          nextState = EMPTY;
        end
      endcase
    end

    assign chRready[c] = rReady;
    assign chWready[c] = wReady;
    assign chRData[c]  = data;
  end

endmodule

// File: tb/tb_port_link.sv
// Scenario bench for port_link: expected words are queued when written and
// checked when the reading side consumes them.
module tb_port_link;
  localparam int WIDTH = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  port_link_if #(.WIDTH(WIDTH)) ifA ();
  port_link_if #(.WIDTH(WIDTH)) ifB ();

  port_link #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (ifA.slave),
    .b   (ifB.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] qAB [$];
  logic [WIDTH-1:0] qBA [$];

  task automatic idle();
    ifA.write = 1'b0; ifA.out = '0; ifA.read = 1'b0;
    ifB.write = 1'b0; ifB.out = '0; ifB.read = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] exp;
    logic bad;
    idle();
    tick();
    checks++;
    if ({ifA.wready, ifB.wready, ifA.rready, ifB.rready, ifA.in, ifB.in} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %b required all zero",
               {ifA.wready, ifB.wready, ifA.rready, ifB.rready, ifA.in, ifB.in});
    end
    rst = 1'b0;
    tick();
    ifA.write = 1'b1; ifA.out = 11'sd123;
    tick();
    ifA.write = 1'b0;
    exp = 11'sd123;
    checks++;
    if (ifB.rready !== 1'b1 || ifB.in !== exp) begin
      errors++;
      $display("FAIL reset_preload: got rready=%b in=%0d required rready=1 in=123",
               ifB.rready, $signed(ifB.in));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifA.wready, ifB.wready, ifA.rready, ifB.rready, ifA.in, ifB.in} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b required all zero",
               {ifA.wready, ifB.wready, ifA.rready, ifB.rready, ifA.in, ifB.in});
    end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifB.rready !== 1'b0 || ifA.wready !== 1'b0 || ifB.in !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_dropped: got rready=%b wready=%b in=%0d required all zero",
               ifB.rready, ifA.wready, $signed(ifB.in));
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp;
    idle();
    ifA.write = 1'b1; ifA.out = -11'sd999;
    qAB.push_back(-11'sd999);
    tick();
    ifA.out = 11'sd55;
    checks++;
    if (ifB.rready !== 1'b1) begin
      errors++;
      $display("FAIL basic_capture_latency: got rready=%b required 1", ifB.rready);
    end
    tick();
    exp = qAB.pop_front();
    checks++;
    if (ifB.rready !== 1'b1 || ifB.in !== exp || ifA.wready !== 1'b0) begin
      errors++;
      $display("FAIL basic_full_data: got rready=%b in=%0d wready=%b required 1 %0d 0",
               ifB.rready, $signed(ifB.in), ifA.wready, $signed(exp));
    end
    ifB.read = 1'b1;
    tick();
    ifB.read = 1'b0;
    checks++;
    if (ifA.wready !== 1'b1 || ifB.rready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got wready=%b rready=%b required 1 0", ifA.wready, ifB.rready);
    end
    // Write stays high into GUARD; it must be ignored there and taken in EMPTY.
    ifA.out = 11'sd77;
    qAB.push_back(11'sd77);
    tick();
    checks++;
    if (ifA.wready !== 1'b0 || ifB.rready !== 1'b0) begin
      errors++;
      $display("FAIL basic_guard: got wready=%b rready=%b required 0 0", ifA.wready, ifB.rready);
    end
    tick();
    checks++;
    if (ifB.rready !== 1'b0 || ifB.in !== -11'sd999) begin
      errors++;
      $display("FAIL basic_guard_ignores_write: got rready=%b in=%0d required 0 -999",
               ifB.rready, $signed(ifB.in));
    end
    tick();
    ifA.write = 1'b0;
    exp = qAB.pop_front();
    checks++;
    if (ifB.rready !== 1'b1 || ifB.in !== exp) begin
      errors++;
      $display("FAIL basic_empty_accepts: got rready=%b in=%0d required 1 %0d",
               ifB.rready, $signed(ifB.in), $signed(exp));
    end
    ifB.read = 1'b1;
    tick();
    ifB.read = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] exp;
    logic bad;
    idle();
    ifA.write = 1'b1; ifA.out = 11'sd5;
    qAB.push_back(11'sd5);
    tick();
    ifA.out = 11'sd7;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifB.rready !== 1'b1 || ifB.in !== 11'sd5 || ifA.wready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stall: got rready=%b in=%0d wready=%b required 1 5 0",
               ifB.rready, $signed(ifB.in), ifA.wready);
    end
    exp = qAB.pop_front();
    checks++;
    if (ifB.in !== exp) begin
      errors++;
      $display("FAIL hold_data: got %0d required %0d", $signed(ifB.in), $signed(exp));
    end
    ifB.read = 1'b1;
    tick();
    ifB.read = 1'b0;
    checks++;
    if (ifA.wready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got wready=%b required 1", ifA.wready);
    end
    ifA.write = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    int cyc, got, acks, lastRise;
    logic prevR, bad;
    idle();
    ifA.write = 1'b1; ifA.out = 11'sd1;
    qAB.push_back(11'sd1);
    cyc = 0; got = 0; acks = 0; lastRise = -1; prevR = 1'b0; bad = 1'b0;
    while ((got < 3 || acks < 3) && cyc < 60) begin
      tick();
      cyc++;
      ifB.read = 1'b0;
      if (ifB.rready === 1'b1) begin
        if (prevR === 1'b0) begin
          if (lastRise >= 0) begin
            checks++;
            if (cyc - lastRise !== 4) begin
              errors++;
              $display("FAIL b2b_period: got %0d cycles required 4", cyc - lastRise);
            end
          end
          lastRise = cyc;
        end
        checks++;
        if (qAB.size() == 0) begin
          errors++;
          $display("FAIL b2b_duplicate: got word %0d required none", $signed(ifB.in));
        end else begin
          exp = qAB.pop_front();
          if (ifB.in !== exp) begin
            errors++;
            $display("FAIL b2b_data: got %0d required %0d", $signed(ifB.in), $signed(exp));
          end
        end
        got++;
        ifB.read = 1'b1;
      end
      prevR = ifB.rready;
      if (ifA.wready === 1'b1) begin
        acks++;
        if (acks < 3) begin
          ifA.out = WIDTH'(acks + 1);
          qAB.push_back(WIDTH'(acks + 1));
        end else begin
          ifA.write = 1'b0;
        end
      end
    end
    ifB.read = 1'b0;
    checks++;
    if (got !== 3 || acks !== 3) begin
      errors++;
      $display("FAIL b2b_count: got words=%0d acks=%0d required 3 3 (cycles %0d)", got, acks, cyc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ifB.rready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_extra_word: got rready=1 after stream required 0");
    end
  endtask

  task automatic test_spurious();
    logic bad;
    idle();
    ifB.read = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifB.rready !== 1'b0 || ifA.wready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL spurious_empty: got rready=%b wready=%b required 0 0", ifB.rready, ifA.wready);
    end
    ifB.read = 1'b0;
    ifA.write = 1'b1; ifA.out = 11'sd300;
    tick();
    ifB.read = 1'b1;
    tick();
    ifA.write = 1'b0;
    checks++;
    if (ifA.wready !== 1'b1 || ifB.rready !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack: got wready=%b rready=%b required 1 0", ifA.wready, ifB.rready);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifB.rready !== 1'b0 || ifA.wready !== 1'b0 || ifB.in !== 11'sd300) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL spurious_guard: got rready=%b wready=%b in=%0d required 0 0 300",
               ifB.rready, ifA.wready, $signed(ifB.in));
    end
    ifB.read = 1'b0;
  endtask

  task automatic test_crossed();
    logic [WIDTH-1:0] expA, expB;
    idle();
    ifA.write = 1'b1; ifA.out = 11'sd10;
    ifB.write = 1'b1; ifB.out = -11'sd20;
    qAB.push_back(11'sd10);
    qBA.push_back(-11'sd20);
    tick();
    checks++;
    if (ifA.rready !== 1'b1 || ifB.rready !== 1'b1 || ifA.wready !== 1'b0 || ifB.wready !== 1'b0) begin
      errors++;
      $display("FAIL crossed_full: got rready a=%b b=%b wready a=%b b=%b required 1 1 0 0",
               ifA.rready, ifB.rready, ifA.wready, ifB.wready);
    end
    tick();
    expA = qBA.pop_front();
    expB = qAB.pop_front();
    checks++;
    if (ifA.in !== expA || ifB.in !== expB) begin
      errors++;
      $display("FAIL crossed_data: got a_in=%0d b_in=%0d required %0d %0d",
               $signed(ifA.in), $signed(ifB.in), $signed(expA), $signed(expB));
    end
    ifA.read = 1'b1; ifB.read = 1'b1;
    tick();
    ifA.read = 1'b0; ifB.read = 1'b0;
    ifA.write = 1'b0; ifB.write = 1'b0;
    checks++;
    if (ifA.wready !== 1'b1 || ifB.wready !== 1'b1) begin
      errors++;
      $display("FAIL crossed_ack: got a_wready=%b b_wready=%b required 1 1", ifA.wready, ifB.wready);
    end
    tick();
    checks++;
    if (ifA.wready !== 1'b0 || ifB.wready !== 1'b0 || ifA.rready !== 1'b0 || ifB.rready !== 1'b0) begin
      errors++;
      $display("FAIL crossed_guard: got wready a=%b b=%b rready a=%b b=%b required all 0",
               ifA.wready, ifB.wready, ifA.rready, ifB.rready);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_spurious();
    test_crossed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
